adxl345_ctrl: RTL

Sequencer sitting directly upstream of `spi_module`. It drives that block's start/address/data handshake to bring the ADXL345 out of standby (optional device-ID check, then BW_RATE, DATA_FORMAT and POWER_CTL writes). It then issues a periodic 6-byte multibyte read of DATAX0..DATAZ1 and publishes signed X/Y/Z samples to the downstream processing logic.

---
 rtl/adxl345_pkg.sv | 33 +++
 rtl/spi_txn_seq.sv | 50 +++++
 rtl/adxl345_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - register map, constants and state encodings shared by adxl345_ctrl
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;

    localparam logic [7:0] DEVID_EXP = 8'hE5;
    localparam logic [2:0] BURST_LEN = 3'd6;

    typedef enum logic [3:0] {
        S_STARTUP,
        S_RD_ID,
        S_CHK_ID,
        S_WR_BW,
        S_WR_FMT,
        S_WR_PWR,
        S_WAIT_TICK,
        S_RD_XYZ,
        S_PUBLISH,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ISSUE,
        T_BUSY,
        T_DONE
    } txn_state_t;

endpackage

// File: rtl/spi_txn_seq.sv
// rtl/spi_txn_seq.sv - start-pulse / busy / done handshake toward spi_module
module spi_txn_seq
    import adxl345_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_go,
    input  logic i_spi_ready,
    output logic o_done,
    output logic o_spi_start
);

    txn_state_t r_state;
    txn_state_t w_state_nxt;
    logic       r_start;
    logic       w_start_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= T_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
        end
    end

    // Start is registered so no i_spi_ready -> o_spi_start combinational path exists.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            T_IDLE:  if (i_go) w_state_nxt = T_ISSUE;
            T_ISSUE: if (i_spi_ready) begin
                w_start_nxt = 1'b1;
                w_state_nxt = T_BUSY;
            end
            T_BUSY:  if (!i_spi_ready) w_state_nxt = T_DONE;
            T_DONE:  if (i_spi_ready) begin
                o_done      = 1'b1;
                w_state_nxt = i_go ? T_ISSUE : T_IDLE;
            end
            default: w_state_nxt = T_IDLE;
        endcase
    end

    assign o_spi_start = r_start;

endmodule

// File: rtl/adxl345_ctrl.sv
// rtl/adxl345_ctrl.sv - ADXL345 bring-up and periodic XYZ burst reader; ADXL345_DEVID_CHECK_EN adds the ID check
module adxl345_ctrl
    import adxl345_pkg::*;
#(
    parameter int         STARTUP_CLKS       = 24000,
    parameter int         SAMPLE_PERIOD_CLKS = 120000,
    parameter logic [7:0] BW_RATE_VAL        = 8'h0A,
    parameter logic [7:0] DATA_FORMAT_VAL    = 8'h08,
    parameter logic [7:0] POWER_CTL_VAL      = 8'h08
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_spi_start,
    output logic        o_spi_rw_n,
    output logic        o_spi_multibyte_rd,
    output logic [5:0]  o_spi_addr,
    output logic [7:0]  o_spi_datain,
    input  logic        i_spi_ready,
    input  logic        i_spi_dataval,
    input  logic [7:0]  i_spi_dataout,
    output logic [15:0] o_accel_x,
    output logic [15:0] o_accel_y,
    output logic [15:0] o_accel_z,
    output logic        o_sample_valid,
    output logic        o_init_done,
    output logic        o_devid_err,
    output logic        o_overrun
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_go;
    logic        w_done;
    logic        w_tick;
    logic [31:0] r_startup_cnt;
    logic [31:0] r_tmr;
    logic [2:0]  r_idx;
    logic [7:0]  r_bytes [0:5];
    logic        r_dv;
    logic [5:0]  r_addr;
    logic        r_rw_n;
    logic        r_mb;
    logic [7:0]  r_datain;
    logic        r_init_done;
    logic        r_overrun;
    logic        r_valid;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_z;

    spi_txn_seq u_txn (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_go        (w_go),
        .i_spi_ready (i_spi_ready),
        .o_done      (w_done),
        .o_spi_start (o_spi_start)
    );

    assign w_tick = r_init_done && (r_tmr == 32'(SAMPLE_PERIOD_CLKS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_STARTUP;
        else       r_state <= w_state_nxt;
    end

    // w_go is raised on entry to every transaction state so the handshake starts immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        case (r_state)
            S_STARTUP: if (r_startup_cnt == 32'(STARTUP_CLKS - 1)) begin
`ifdef ADXL345_DEVID_CHECK_EN
                w_state_nxt = S_RD_ID;
`else
                w_state_nxt = S_WR_BW;
`endif
                w_go = 1'b1;
            end
`ifdef ADXL345_DEVID_CHECK_EN
            S_RD_ID:   if (w_done) w_state_nxt = S_CHK_ID;
            S_CHK_ID:  if (r_bytes[0] != DEVID_EXP) begin
                w_state_nxt = S_ERROR;
            end else begin
                w_state_nxt = S_WR_BW;
                w_go        = 1'b1;
            end
`endif
            S_WR_BW:   if (w_done) begin
                w_state_nxt = S_WR_FMT;
                w_go        = 1'b1;
            end
            S_WR_FMT:  if (w_done) begin
                w_state_nxt = S_WR_PWR;
                w_go        = 1'b1;
            end
            S_WR_PWR:  if (w_done) w_state_nxt = S_WAIT_TICK;
            S_WAIT_TICK: if (w_tick) begin
                w_state_nxt = S_RD_XYZ;
                w_go        = 1'b1;
            end
            S_RD_XYZ:  if (w_done) w_state_nxt = (r_idx == BURST_LEN) ? S_PUBLISH : S_WAIT_TICK;
            S_PUBLISH: w_state_nxt = S_WAIT_TICK;
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = S_STARTUP;
        endcase
    end

    // Fields follow the next state so they are already stable when the start pulse leaves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr   <= 6'h00;
            r_rw_n   <= 1'b0;
            r_mb     <= 1'b0;
            r_datain <= 8'h00;
        end else begin
            case (w_state_nxt)
                S_RD_ID:  begin r_addr <= ADDR_DEVID;       r_rw_n <= 1'b1; r_mb <= 1'b0; r_datain <= 8'h00; end
                S_WR_BW:  begin r_addr <= ADDR_BW_RATE;     r_rw_n <= 1'b0; r_mb <= 1'b0; r_datain <= BW_RATE_VAL; end
                S_WR_FMT: begin r_addr <= ADDR_DATA_FORMAT; r_rw_n <= 1'b0; r_mb <= 1'b0; r_datain <= DATA_FORMAT_VAL; end
                S_WR_PWR: begin r_addr <= ADDR_POWER_CTL;   r_rw_n <= 1'b0; r_mb <= 1'b0; r_datain <= POWER_CTL_VAL; end
                S_RD_XYZ: begin r_addr <= ADDR_DATAX0;      r_rw_n <= 1'b1; r_mb <= 1'b1; r_datain <= {5'd0, BURST_LEN}; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_startup_cnt <= 32'd0;
            r_tmr         <= 32'd0;
            r_init_done   <= 1'b0;
            r_overrun     <= 1'b0;
            r_dv          <= 1'b0;
            r_idx         <= 3'd0;
            r_valid       <= 1'b0;
            r_x           <= 16'h0000;
            r_y           <= 16'h0000;
            r_z           <= 16'h0000;
        end else begin
            r_dv      <= i_spi_dataval;
            r_overrun <= w_tick && (r_state == S_RD_XYZ || r_state == S_PUBLISH);
            r_valid   <= 1'b0;
            if (r_state == S_STARTUP) r_startup_cnt <= r_startup_cnt + 32'd1;
            if (r_state == S_WR_PWR && w_done) begin
                r_init_done <= 1'b1;
                r_tmr       <= 32'd0;
            end else if (r_init_done) begin
                r_tmr <= w_tick ? 32'd0 : r_tmr + 32'd1;
            end
            if (w_go)                            r_idx <= 3'd0;
            else if (r_dv && r_idx != BURST_LEN) r_idx <= r_idx + 3'd1;
            if (r_state == S_RD_XYZ && w_done && r_idx == BURST_LEN) begin
                r_x     <= {r_bytes[1], r_bytes[0]};
                r_y     <= {r_bytes[3], r_bytes[2]};
                r_z     <= {r_bytes[5], r_bytes[4]};
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!w_go && r_dv && r_idx != BURST_LEN) r_bytes[r_idx] <= i_spi_dataout;
    end

`ifdef ADXL345_DEVID_CHECK_EN
    logic r_devid_err;
    always_ff @(posedge i_clk) begin
        if (i_rst)                                             r_devid_err <= 1'b0;
        else if (r_state == S_CHK_ID && r_bytes[0] != DEVID_EXP) r_devid_err <= 1'b1;
    end
    assign o_devid_err = r_devid_err;
`else
    assign o_devid_err = 1'b0;
`endif

    assign o_spi_rw_n         = r_rw_n;
    assign o_spi_multibyte_rd = r_mb;
    assign o_spi_addr         = r_addr;
    assign o_spi_datain       = r_datain;
    assign o_accel_x          = r_x;
    assign o_accel_y          = r_y;
    assign o_accel_z          = r_z;
    assign o_sample_valid     = r_valid;
    assign o_init_done        = r_init_done;
    assign o_overrun          = r_overrun;

endmodule
